// File: rtl/rca_pipe.sv
// -----------------------------------------------------------------------------
// rca_pipe
//   Pipelined ripple-carry adder/subtractor. A WIDTH-bit add is split into
//   STAGES = WIDTH/CHUNK chunk-wide ripple stages, with one register rank per
//   stage. Operands travel skewed through the ranks, so each stage adds one
//   chunk per cycle. This gives full throughput and a fixed latency of STAGES
//   cycles.
//
//   A global stall holds every rank while the consumer applies backpressure.
//
// Parameters
//   WIDTH  operand/sum width (must be a multiple of CHUNK)
//   CHUNK  bits rippled per stage
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   operands present on x/y/c_in/sub
//   in_ready   pipe accepts an operation this cycle
//   x, y       operands (WIDTH)
//   c_in       carry-in, add mode only
//   sub        0: x+y+c_in, 1: x+~y+1
//   out_valid  result present on s/c_out
//   out_ready  consumer accepts the result this cycle
//   s          sum/difference (WIDTH)
//   c_out      carry-out (subtract: 1 = no borrow)
//   ovf        signed overflow, present only when RCA_PIPE_OVF_EN is defined
// -----------------------------------------------------------------------------
module rca_pipe #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out
`ifdef RCA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_cfg
    $error("rca_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  // Ripple one chunk; returns {carry_out, sum}.
  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] a,
                                               input logic [CHUNK-1:0] b,
                                               input logic             ci);
    logic             c;
    logic [CHUNK-1:0] sm;
    c  = ci;
    sm = '0;
    for (int i = 0; i < CHUNK; i++) begin
      sm[i] = a[i] ^ b[i] ^ c;
      c     = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return {c, sm};
  endfunction

  // Rank k holds: remaining operand bits, finished sum chunks 0..k,
  // carry out of chunk k, and the rank's valid bit.
  logic [WIDTH-1:0] r_x_p   [STAGES];
  logic [WIDTH-1:0] r_y_p   [STAGES];
  logic [WIDTH-1:0] r_s_p   [STAGES];
  logic             r_c_p   [STAGES];
  logic             r_vld_p [STAGES];

  // Stage inputs, taken from the ports for stage 0 and from rank k-1 otherwise.
  logic [WIDTH-1:0] w_src_x [STAGES];
  logic [WIDTH-1:0] w_src_y [STAGES];
  logic [WIDTH-1:0] w_src_s [STAGES];
  logic             w_src_c [STAGES];
  logic             w_src_v [STAGES];
  logic [WIDTH-1:0] w_nxt_s [STAGES];
  logic             w_nxt_c [STAGES];
  logic [CHUNK:0]   w_res;
  logic             w_adv;

  assign w_adv     = ~r_vld_p[LAST] | out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld_p[LAST];
  assign s         = r_s_p[LAST];
  assign c_out     = r_c_p[LAST];

  always_comb begin
    // In subtract mode, y is inverted once at entry and the carry is forced to 1.
    w_src_x[0] = x;
    w_src_y[0] = sub ? ~y : y;
    w_src_s[0] = '0;
    w_src_c[0] = sub ? 1'b1 : c_in;
    w_src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      w_src_x[k] = r_x_p[k-1];
      w_src_y[k] = r_y_p[k-1];
      w_src_s[k] = r_s_p[k-1];
      w_src_c[k] = r_c_p[k-1];
      w_src_v[k] = r_vld_p[k-1];
    end
    w_res = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_res      = add_chunk(w_src_x[k][k*CHUNK +: CHUNK],
                             w_src_y[k][k*CHUNK +: CHUNK], w_src_c[k]);
      w_nxt_s[k] = w_src_s[k];
      w_nxt_s[k][k*CHUNK +: CHUNK] = w_res[CHUNK-1:0];
      w_nxt_c[k] = w_res[CHUNK];
    end
  end

  // ---- rank registers: valid control (reset) ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) r_vld_p[k] <= 1'b0;
    end else if (w_adv) begin
      for (int k = 0; k < STAGES; k++) r_vld_p[k] <= w_src_v[k];
    end
  end

  // ---- rank registers: data (empty ranks shift too) ----
  always_ff @(posedge clk) begin
    if (w_adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_x_p[k] <= w_src_x[k];
        r_y_p[k] <= w_src_y[k];
        r_s_p[k] <= w_nxt_s[k];
        r_c_p[k] <= w_nxt_c[k];
      end
    end
    // The visible result is cleared on reset; inner data ranks are don't-care.
    if (rst) begin
      r_s_p[LAST] <= '0;
      r_c_p[LAST] <= 1'b0;
    end
  end

`ifdef RCA_PIPE_OVF_EN
  // The carry into the MSB is recovered as sum ^ a ^ b at that bit.
  logic r_ovf_p;
  logic w_ovf;
  assign w_ovf = w_nxt_s[LAST][WIDTH-1] ^ w_src_x[LAST][WIDTH-1] ^
                 w_src_y[LAST][WIDTH-1] ^ w_nxt_c[LAST];

  always_ff @(posedge clk) begin
    if (rst)        r_ovf_p <= 1'b0;
    else if (w_adv) r_ovf_p <= w_ovf;
  end
  assign ovf = r_ovf_p;
`endif

endmodule
